// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: expands one multiple-register instruction
// into single-word memory transfers plus an optional base-register writeback.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reglist,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  ra,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        pc_we,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] final_q, final_d;
    logic        load_q, load_d;
    logic [3:0]  rn_q, rn_d;
    logic        wb_q, wb_d;

    logic [4:0]  n;
    logic [31:0] n4;
    logic [3:0]  cur;
    logic        last;

    always_comb begin
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, reglist[i]};
        n4 = {25'd0, n, 2'b00};
    end

    // Lowest set bit of the remaining mask: registers go out in ascending order.
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--) if (mask_q[i]) cur = 4'(i);
        last = (mask_q & (mask_q - 16'd1)) == 16'd0;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        final_d  = final_q;
        load_d   = load_q;
        rn_d     = rn_q;
        wb_d     = wb_q;
        busy     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        ra       = '0;
        we3      = 1'b0;
        wa3      = '0;
        wd3      = '0;
        pc_we    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_d  = is_load;
                    rn_d    = rn;
                    mask_d  = reglist;
                    // A base register that is itself loaded takes precedence over writeback.
                    wb_d    = wback && !(is_load && reglist[rn]);
                    final_d = up ? base + n4 : base - n4;
                    case ({up, pre})
                        2'b10:   addr_d = base;
                        2'b11:   addr_d = base + 32'd4;
                        2'b00:   addr_d = base - n4 + 32'd4;
                        default: addr_d = base - n4;
                    endcase
                    state_d = (n == 5'd0) ? DONE : XFER;
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = addr_q;
                ra       = load_q ? 4'd0 : cur;
                if (mem_ready) begin
                    mask_d = mask_q & ~(16'd1 << cur);
                    addr_d = addr_q + 32'd4;
                    if (load_q) begin
                        wa3   = cur;
                        wd3   = mem_rdata;
                        we3   = (cur != 4'd15);
                        pc_we = (cur == 4'd15);
                    end
                    if (last) state_d = wb_q ? WB : DONE;
                end
            end
            WB: begin
                busy    = 1'b1;
                we3     = 1'b1;
                wa3     = rn_q;
                wd3     = final_q;
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            load_q  <= 1'b0;
            rn_q    <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            final_q <= final_d;
            load_q  <= load_d;
            rn_q    <= rn_d;
            wb_q    <= wb_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: table of directed transfers, randomized
// transfers against a register-list model, and reset-abort sequence.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [15:0] reglist;
    logic [3:0]  rn;
    logic [31:0] base;
    logic        up;
    logic        pre;
    logic        wback;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy, mem_req, mem_we, we3, pc_we, done;
    logic [31:0] mem_addr, wd3;
    logic [3:0]  ra, wa3;

    int n_checks = 0;
    int n_fail   = 0;

    ldm_stm_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .reglist(reglist), .rn(rn), .base(base), .up(up), .pre(pre),
        .wback(wback), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .ra(ra), .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {busy, mem_req, mem_we, mem_addr, ra, we3, wa3, wd3, pc_we, done}
    logic [77:0] dut_vec;
    assign dut_vec = {busy, mem_req, mem_we, mem_addr, ra, we3, wa3, wd3, pc_we, done};

    function automatic logic [77:0] pack(input logic b, input logic rq, input logic we,
                                         input logic [31:0] ad, input logic [3:0] r,
                                         input logic w3, input logic [3:0] a3,
                                         input logic [31:0] d3, input logic pw,
                                         input logic dn);
        return {b, rq, we, ad, r, w3, a3, d3, pw, dn};
    endfunction

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from IDLE and checks every cycle against a model built
    // from the ordered register list. Returns the DUT's start-to-done latency and
    // the first address it presented.
    task automatic run_txn(input logic ld, input logic [15:0] rl, input logic [3:0] r_n,
                           input logic [31:0] b, input logic u, input logic p,
                           input logic w, input int force_stall, input int stall_pct,
                           input bit noise, output int lat, output logic [31:0] first);
        int          regs[$];
        int          n, k, stalls;
        bit          wb_pend, finished, r;
        logic [31:0] saddr, fbase, rd;
        logic [77:0] exp;

        regs = {};
        for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
        n       = regs.size();
        fbase   = u ? b + 32'(4 * n) : b - 32'(4 * n);
        saddr   = u ? b + (p ? 32'd4 : 32'd0) : b - 32'(4 * n) + (p ? 32'd0 : 32'd4);
        wb_pend = (n != 0) && w && !(ld && rl[r_n]);
        k = 0; stalls = 0; finished = 0; lat = -1; first = 'x;

        start = 1'b1; is_load = ld; reglist = rl; rn = r_n; base = b;
        up = u; pre = p; wback = w; mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        check("start_cycle_idle", dut_vec, '0);
        @(posedge clk); #1;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (stalls < force_stall) begin
                r = 0; stalls++;
            end else begin
                r = ($urandom_range(99) >= stall_pct);
            end
            rd = $urandom;
            mem_ready = r; mem_rdata = rd;
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            if (noise) begin
                is_load = 1'($urandom); reglist = 16'($urandom); rn = 4'($urandom);
                base = $urandom; up = 1'($urandom); pre = 1'($urandom); wback = 1'($urandom);
            end
            @(negedge clk);
            if (k < n) begin
                exp = pack(1, 1, !ld, saddr + 32'(4 * k), ld ? 4'd0 : 4'(regs[k]),
                           ld && r && regs[k] != 15, (ld && r) ? 4'(regs[k]) : 4'd0,
                           (ld && r) ? rd : 32'd0, ld && r && regs[k] == 15, 0);
                check("xfer_cycle", dut_vec, exp);
                if (r) k++;
            end else if (wb_pend) begin
                check("wb_cycle", dut_vec, pack(1, 0, 0, 0, 0, 1, r_n, fbase, 0, 0));
                wb_pend = 0;
            end else begin
                check("done_cycle", dut_vec, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
                finished = 1;
            end
            if (cyc == 1) first = mem_addr;
            if (done === 1'b1 && lat < 0) lat = cyc;
            @(posedge clk); #1;
            if (finished) break;
        end
        if (!finished) begin
            n_checks++; n_fail++;
            $display("FAIL txn_timeout: got no completion expected done within 400 cycles");
        end
        start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("idle_after", dut_vec, '0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       name;
        logic        ld;
        logic [15:0] rl;
        logic [3:0]  rn;
        logic [31:0] base;
        logic        up, pre, wb;
        int          stall;
        int          exp_lat;
        logic [31:0] exp_first;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          lat;
        logic [31:0] first;

        tbl[0] = '{"stmia_wb",   0, 16'h0016, 4'd0,  32'h0000_0100, 1, 0, 1, 0, 5, 32'h0000_0100};
        tbl[1] = '{"ldmdb_wb",   1, 16'h4003, 4'd13, 32'h0000_0200, 0, 1, 1, 0, 5, 32'h0000_01F4};
        tbl[2] = '{"ldm_base",   1, 16'h0006, 4'd2,  32'h0000_0080, 1, 0, 1, 0, 3, 32'h0000_0080};
        tbl[3] = '{"ldm_pc",     1, 16'h8000, 4'd0,  32'h0000_0040, 1, 0, 0, 0, 2, 32'h0000_0040};
        tbl[4] = '{"stmib_stal", 0, 16'h0001, 4'd5,  32'h0000_0500, 1, 1, 0, 3, 5, 32'h0000_0504};
        tbl[5] = '{"empty_list", 0, 16'h0000, 4'd3,  32'h0000_0010, 1, 0, 1, 0, 1, 32'h0000_0000};
        tbl[6] = '{"stmda_wb",   0, 16'h00F0, 4'd1,  32'h0000_1000, 0, 0, 1, 0, 6, 32'h0000_0FF4};
        tbl[7] = '{"stmib_wrap", 0, 16'h0003, 4'd4,  32'hFFFF_FFFC, 1, 1, 1, 0, 4, 32'h0000_0000};

        reset = 1'b0; start = 1'b0; is_load = 1'b0; reglist = '0; rn = '0; base = '0;
        up = 1'b0; pre = 1'b0; wback = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", dut_vec, '0);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_txn(tbl[i].ld, tbl[i].rl, tbl[i].rn, tbl[i].base, tbl[i].up, tbl[i].pre,
                    tbl[i].wb, tbl[i].stall, 0, (tbl[i].stall != 0), lat, first);
            check_int({tbl[i].name, "_latency"}, lat, tbl[i].exp_lat);
            check({tbl[i].name, "_first_addr"}, {46'd0, first}, {46'd0, tbl[i].exp_first});
        end

        for (int t = 0; t < 40; t++) begin
            logic [15:0] rl;
            rl = 16'($urandom);
            case ($urandom_range(7))
                0: rl = 16'h0000;
                1: rl = 16'hFFFF;
                2: rl = rl & 16'h8421;
                default: ;
            endcase
            run_txn(1'($urandom), rl, 4'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(2), 30, 1, lat, first);
        end

        // Reset during the second transfer of a four-register load.
        start = 1'b1; is_load = 1'b1; reglist = 16'h000F; rn = 4'd9; base = 32'h300;
        up = 1'b1; pre = 1'b0; wback = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hAAAA_0000;
        @(posedge clk); #1;
        start = 1'b0; mem_rdata = 32'hAAAA_0001;
        @(negedge clk);
        check("abort_xfer0", dut_vec, pack(1, 1, 0, 32'h300, 0, 1, 4'd0, 32'hAAAA_0001, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0; mem_rdata = 32'hAAAA_0002;
        @(negedge clk);
        check("abort_xfer1", dut_vec, pack(1, 1, 0, 32'h304, 0, 1, 4'd1, 32'hAAAA_0002, 0, 0));
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_quiet", dut_vec, '0);
            @(posedge clk); #1;
        end

        run_txn(0, 16'h0000, 4'd0, 32'h20, 1, 0, 1, 0, 0, 0, lat, first);
        check_int("post_abort_empty_latency", lat, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Block-transfer sequencer for the ARM datapath register file. It expands one LDM/STM instruction into a series of single-word memory transfers. For stores it drives the register file read address; for loads it drives the write port (we3/wa3/wd3). When requested, it finishes with the base-register writeback. The datapath holds its fetch stage while `busy` is high.

## Interface
Parameters: none (32-bit datapath, 16 architectural registers, fixed).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin transfer; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- reglist  in  16  register list, bit i = Ri
- rn  in  4  base register index
- base  in  32  value of Rn, sampled with start
- up  in  1  U bit: 1 = increment, 0 = decrement
- pre  in  1  P bit: 1 = before, 0 = after
- wback  in  1  W bit: base writeback
- mem_ready  in  1  memory completes current word this cycle
- mem_rdata  in  32  load data, valid when mem_ready
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  memory access request
- mem_we  out  1  write enable (STM)
- mem_addr  out  32  word address of current transfer
- ra  out  4  register file read address, feeds the ra2 port for store data
- we3  out  1  register file write enable
- wa3  out  4  register file write address
- wd3  out  32  register file write data
- pc_we  out  1  load of R15; goes to the PC register, never to we3
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE, start=1: latch is_load, rn, wback and the mask (= reglist). Compute n = popcount(reglist), range 0..16.
- Start address, 32-bit wrap-around arithmetic:
  - IA: base
  - IB: base+4
  - DA: base−4n+4
  - DB: base−4n
- Final base: base+4n if up, else base−4n. Latch both values.
- Next state after start: XFER if n≠0; DONE if n=0 (no transfer, no writeback).
- XFER:
  - cur = lowest set bit of mask. Registers go in ascending index order at ascending addresses.
  - mem_req=1, mem_addr=current address.
  - STM: mem_we=1, ra=cur.
  - On mem_ready: clear bit cur and add 4 to the address.
  - LDM with mem_ready: we3=1, wa3=cur, wd3=mem_rdata in the same cycle. If cur=15, pc_we=1 and we3=0.
  - When the last bit clears, go to WB if wback=1 and NOT (is_load and reglist[rn]), else go to DONE. A loaded base wins over writeback.
- WB: we3=1, wa3=rn, wd3=final base, for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- Outputs not listed for a state are 0 (ra=0, wa3=0, wd3=0, mem_addr=0).

## Timing
- Reset (reset=0 at a rising edge): state IDLE, mask cleared, every output 0.
- Reset mid-operation aborts at once: no further we3, pc_we or mem_req. A transfer already completed stays completed.
- busy rises the cycle after start is accepted. It stays high until the DONE cycle, which is its last cycle.
- With mem_ready held at 1: n XFER cycles + 1 WB cycle (if taken) + 1 DONE cycle. start to done = n+2 cycles, or n+1 without WB. The n=0 case takes 1 cycle.
- mem_ready=0 holds mem_req, mem_addr, mem_we and ra stable. No register write occurs while stalled.
- we3/pc_we are combinational within XFER and are registered by the register file on the same edge that advances the sequencer.

## Test plan
- STMIA, W=1, rn=0, base=0x100, reglist=0x0016, mem_ready=1:
  - writes at 0x100/0x104/0x108 with ra=1,2,4
  - WB cycle wa3=0, wd3=0x10C
  - done 5 cycles after start
- LDMDB, W=1, rn=13, base=0x200, reglist=0x4003, rdata=A,B,C:
  - addresses 0x1F4/0x1F8/0x1FC
  - writes R0=A, R1=B, R14=C
  - WB wd3=0x1F4
- LDMIA, W=1, rn=2, reglist=0x0006: R2 is loaded from memory and no WB cycle occurs; done after 3 cycles.
- LDMIA, reglist=0x8000, base=0x40: pc_we=1 with wd3=rdata, we3 stays 0; busy/done timing as above.
- STMIB, reglist=0x0001, mem_ready low for 3 cycles:
  - mem_addr=base+4 held stable during the stall
  - one transfer completes
  - start pulses during busy have no effect
- Reset asserted during the second XFER transfer of a 4-register LDM: the next cycle shows IDLE, busy=0, and no further writes. reglist=0 gives done one cycle after start with no mem_req.
